video_timing_gen: RTL
=====================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch
- H_SYNC, 128, hsync width
- H_BP, 88, horizontal back porch
- V_ACTIVE, 600, visible lines
- V_FP, 1, vertical front porch
- V_SYNC, 4, vsync width
- V_BP, 23, vertical back porch
- H_BORDER, 0, border pixels at each end of an active line
- V_BORDER, 0, border lines at top and bottom of the active frame
- HSYNC_POL, 1, hsync asserted level
- VSYNC_POL, 1, vsync asserted level
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, pixel clock, the only clock
- rst_i, in, 1, synchronous active-high reset
- en_i, in, 1, timing enable
- border_color_i, in, 32, border pixel value
- underflow_color_i, in, 32, value substituted on starvation
- pix_data_i, in, 32, upstream pixel
- pix_valid_i, in, 1, upstream pixel valid
- pix_ready_o, out, 1, pixel accepted this cycle
- hsync_o, vsync_o, blank_o, border_o, out, 1 each, video_bus out-side controls
- data_o, out, 32, video_bus pixel data
- sof_o, out, 1, start-of-frame pulse
- underflow_o, out, 1, sticky starvation flag
- underflow_clr_i, in, 1, clears underflow_o
REQ-003 Outputs hsync_o..data_o SHALL drive the out modport of the video_bus interface; clk of that interface SHALL be clk_i.

Function
REQ-010 hcnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H_ACTIVE, H_FP, H_SYNC, H_BP); on wrap it SHALL reset to 0 and advance vcnt over 0..V_TOTAL-1, which SHALL itself wrap to 0.
REQ-011 Counter widths SHALL be $clog2(total); wrap SHALL compare against total-1, never rely on overflow.
REQ-012 Horizontal regions SHALL be: active hcnt<H_ACTIVE; FP next; SYNC next; BP last. Vertical regions SHALL be analogous on vcnt.
REQ-013 blank SHALL be 1 outside both active regions; border SHALL be 1 when active and hcnt<H_BORDER, hcnt>=H_ACTIVE-H_BORDER, vcnt<V_BORDER, or vcnt>=V_ACTIVE-V_BORDER.
REQ-014 pix_ready_o SHALL be combinational from current counters: 1 iff en_i, active, and not border.
REQ-015 A transfer SHALL occur when pix_ready_o and pix_valid_i are both 1.
REQ-016 data_o SHALL take the following value, by priority:
- pix_data_i on a transfer
- border_color_i when border
- underflow_color_i when pixel slot with pix_valid_i=0
- 0 when blank
REQ-017 A pixel slot with pix_valid_i=0 SHALL set underflow_o; underflow_clr_i SHALL clear it; simultaneous set and clear SHALL leave it set.
REQ-018 All outputs except pix_ready_o SHALL be registered: latency 1 cycle from the counter state that generated them.
REQ-019 sof_o SHALL pulse 1 cycle, aligned with the first output pixel of hcnt=0 and vcnt=0.
REQ-020 en_i=0 SHALL hold counters at 0 and force blank_o=1, syncs deasserted, and data_o=0.
REQ-021 en_i going 1 SHALL start at hcnt=vcnt=0.
REQ-022 Sync outputs SHALL equal the POL parameter when asserted and its inverse otherwise.

Reset
REQ-030 On rst_i, hcnt and vcnt SHALL be 0.
REQ-031 On rst_i, outputs SHALL be: blank_o=1, border_o=0, data_o=0, sof_o=0, underflow_o=0, syncs deasserted.
REQ-032 Reset mid-frame SHALL abandon the frame with no pixel transferred in the reset cycle.

Configuration
REQ-040 With VIDEO_TPG_EN defined, pix_data_i SHALL be ignored, pix_ready_o SHALL be 0, and pixel slots SHALL carry {8'h00, hcnt[7:0], vcnt[7:0], hcnt[7:0]^vcnt[7:0]}, with no underflow.
REQ-041 Without VIDEO_TPG_EN, REQ-014..REQ-017 SHALL apply unchanged.

Structure
REQ-050 video_pkg SHALL hold typedef video_region_t (ACTIVE, FP, SYNC, BP) and the default timing constants.
REQ-051 One sub-module, video_axis_counter, SHALL implement one axis (counter, region decode, wrap strobe), instantiated as horizontal and vertical, with the horizontal wrap strobe enabling the vertical.

Verification
REQ-060 H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V=1/1/1, free-running source: hsync_o high 2 cycles every 14, sof_o every 98 cycles.
REQ-061 Same timing, H_BORDER=1, border_color_i=32'hFF: pixels 0 and 7 of each line = 32'hFF with border_o=1; 6 transfers per line.
REQ-062 pix_valid_i=0 for one slot, underflow_color_i=32'hDEAD: that data_o = 32'hDEAD and underflow_o sticks until underflow_clr_i.
REQ-063 rst_i asserted at hcnt=5, vcnt=2: next cycle blank_o=1, data_o=0, and the next sof_o occurs 98 cycles after release.
REQ-064 en_i=0 for 20 cycles mid-line: no transfers, blank_o=1; the first pixel after re-enable comes with sof_o=1.
REQ-065 VIDEO_TPG_EN defined: pixel at hcnt=3, vcnt=1 = 32'h00030102, and pix_ready_o=0 throughout.

Source files
------------

// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared types and default timing for the video timing generator.
//   video_region_t : position of a counter within one axis (ACTIVE, FP, SYNC, BP)
//   DEF_*          : default 800x600 @ 40 MHz style timing constants
//   tpg_pixel()    : test-pattern pixel for a given (h, v) position
// -----------------------------------------------------------------------------
package video_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FP     = 2'd1,
        SYNC   = 2'd2,
        BP     = 2'd3
    } video_region_t;

    localparam int unsigned DEF_H_ACTIVE = 800;
    localparam int unsigned DEF_H_FP     = 40;
    localparam int unsigned DEF_H_SYNC   = 128;
    localparam int unsigned DEF_H_BP     = 88;
    localparam int unsigned DEF_V_ACTIVE = 600;
    localparam int unsigned DEF_V_FP     = 1;
    localparam int unsigned DEF_V_SYNC   = 4;
    localparam int unsigned DEF_V_BP     = 23;
    localparam int unsigned DEF_H_BORDER = 0;
    localparam int unsigned DEF_V_BORDER = 0;

    localparam int unsigned PIX_W = 32;

    // Pattern: {0, h, v, h^v} using the low byte of each counter.
    function automatic logic [PIX_W-1:0] tpg_pixel(input logic [7:0] h, input logic [7:0] v);
        return {8'h00, h, v, h ^ v};
    endfunction

endpackage

// File: rtl/video_bus.sv
// -----------------------------------------------------------------------------
// video_bus
// Pixel-clock synchronous video bus (controls plus 32-bit pixel data).
//   clk    : pixel clock
//   hsync, vsync, blank, border : line/frame controls
//   data   : pixel value
// Modports: out (source side), in (sink side).
// -----------------------------------------------------------------------------
interface video_bus (input logic clk);
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic        border;
    logic [31:0] data;

    modport out (input clk, output hsync, vsync, blank, border, data);
    modport in  (input clk, input  hsync, vsync, blank, border, data);
endinterface

// File: rtl/video_axis_counter.sv
// -----------------------------------------------------------------------------
// video_axis_counter
// One timing axis: counts 0..TOTAL-1 on each step, decodes the region and
// emits a wrap strobe on the step that returns the count to 0.
// Ports:
//   clk_i    : pixel clock
//   rst_i    : synchronous active-high reset (count -> 0)
//   clr_i    : hold count at 0 (timing disabled)
//   step_i   : advance one position
//   cnt_o    : current position
//   region_o : ACTIVE / FP / SYNC / BP for the current position
//   wrap_o   : step_i on the last position (count wraps this cycle)
// -----------------------------------------------------------------------------
module video_axis_counter
    import video_pkg::*;
#(
    parameter  int unsigned ACT_LEN  = DEF_H_ACTIVE,
    parameter  int unsigned FP_LEN   = DEF_H_FP,
    parameter  int unsigned SYNC_LEN = DEF_H_SYNC,
    parameter  int unsigned BP_LEN   = DEF_H_BP,
    localparam int unsigned TOTAL    = ACT_LEN + FP_LEN + SYNC_LEN + BP_LEN,
    localparam int unsigned W        = $clog2(TOTAL)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          step_i,
    output logic [W-1:0]  cnt_o,
    output video_region_t region_o,
    output logic          wrap_o
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] cnt_d, cnt_q;
    logic         last;

    // Explicit compare against the last position; TOTAL is rarely a power of 2.
    always_comb begin
        last  = (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (step_i) begin
            cnt_d = last ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Compare in 32 bits so a zero-length back porch cannot alias to 0.
    always_comb begin
        region_o = BP;
        if (32'(cnt_q) < ACT_LEN) begin
            region_o = ACTIVE;
        end else if (32'(cnt_q) < ACT_LEN + FP_LEN) begin
            region_o = FP;
        end else if (32'(cnt_q) < ACT_LEN + FP_LEN + SYNC_LEN) begin
            region_o = SYNC;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = step_i & last & ~clr_i;

endmodule

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
// Raster timing generator with pixel-stream input. Produces registered
// hsync/vsync/blank/border/data on a video_bus, a start-of-frame pulse and a
// sticky underflow flag when the upstream source misses a pixel slot.
// Ports:
//   clk_i, rst_i          : pixel clock, synchronous active-high reset
//   en_i                  : timing enable (0 holds counters at the frame origin)
//   border_color_i        : value driven on border pixels
//   underflow_color_i     : value driven when a pixel slot has no valid pixel
//   pix_data_i/pix_valid_i/pix_ready_o : upstream pixel handshake
//   hsync_o, vsync_o, blank_o, border_o, data_o : video outputs (1-cycle latency)
//   sof_o                 : 1-cycle pulse with the first pixel of each frame
//   underflow_o           : sticky starvation flag, cleared by underflow_clr_i
// Build option: VIDEO_TPG_EN replaces the upstream stream by a test pattern.
// -----------------------------------------------------------------------------
module video_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter int unsigned H_BORDER  = DEF_H_BORDER,
    parameter int unsigned V_BORDER  = DEF_V_BORDER,
    parameter bit          HSYNC_POL = 1'b1,
    parameter bit          VSYNC_POL = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [31:0] border_color_i,
    input  logic [31:0] underflow_color_i,
    input  logic [31:0] pix_data_i,
    input  logic        pix_valid_i,
    output logic        pix_ready_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        blank_o,
    output logic        border_o,
    output logic [31:0] data_o,
    output logic        sof_o,
    output logic        underflow_o,
    input  logic        underflow_clr_i
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    video_region_t h_region, v_region;
    logic          h_wrap;
    // The frame wrap is implied by the counters returning to (0,0); sof decodes that directly.
    logic          v_wrap_unused;

    video_axis_counter #(
        .ACT_LEN (H_ACTIVE),
        .FP_LEN  (H_FP),
        .SYNC_LEN(H_SYNC),
        .BP_LEN  (H_BP)
    ) u_h_axis (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (~en_i),
        .step_i  (en_i),
        .cnt_o   (hcnt),
        .region_o(h_region),
        .wrap_o  (h_wrap)
    );

    video_axis_counter #(
        .ACT_LEN (V_ACTIVE),
        .FP_LEN  (V_FP),
        .SYNC_LEN(V_SYNC),
        .BP_LEN  (V_BP)
    ) u_v_axis (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (~en_i),
        .step_i  (h_wrap),
        .cnt_o   (vcnt),
        .region_o(v_region),
        .wrap_o  (v_wrap_unused)
    );

    // Decode of the current counter position.
    logic active, border, slot, pix_ready, xfer, uf_set;

    logic        hsync_d, hsync_q;
    logic        vsync_d, vsync_q;
    logic        blank_d, blank_q;
    logic        border_d, border_q;
    logic [31:0] data_d, data_q;
    logic        sof_d, sof_q;
    logic        underflow_d, underflow_q;

    always_comb begin
        // en_i folded in here so a disabled generator looks fully blanked.
        active = en_i && (h_region == ACTIVE) && (v_region == ACTIVE);
        border = active && ((32'(hcnt) <  H_BORDER) ||
                            (32'(hcnt) >= H_ACTIVE - H_BORDER) ||
                            (32'(vcnt) <  V_BORDER) ||
                            (32'(vcnt) >= V_ACTIVE - V_BORDER));
        slot   = active && !border;
`ifdef VIDEO_TPG_EN
        pix_ready = 1'b0;
        uf_set    = 1'b0;
`else
        // No handshake during reset: the abandoned frame takes no pixel.
        pix_ready = slot && !rst_i;
        uf_set    = slot && !pix_valid_i;
`endif
        xfer = pix_ready && pix_valid_i;
    end

    assign pix_ready_o = pix_ready;

    always_comb begin
        hsync_d  = (en_i && h_region == SYNC) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d  = (en_i && v_region == SYNC) ? VSYNC_POL : ~VSYNC_POL;
        blank_d  = !active;
        border_d = border;
        sof_d    = en_i && (hcnt == '0) && (vcnt == '0);

        data_d = '0;
        if (xfer) begin
            data_d = pix_data_i;
        end else if (border) begin
            data_d = border_color_i;
        end else if (slot) begin
`ifdef VIDEO_TPG_EN
            data_d = tpg_pixel(8'(hcnt), 8'(vcnt));
`else
            data_d = underflow_color_i;
`endif
        end

        // A new starvation event wins over a clear in the same cycle.
        if (uf_set) begin
            underflow_d = 1'b1;
        end else if (underflow_clr_i) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hsync_q     <= ~HSYNC_POL;
            vsync_q     <= ~VSYNC_POL;
            blank_q     <= 1'b1;
            border_q    <= 1'b0;
            data_q      <= '0;
            sof_q       <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            blank_q     <= blank_d;
            border_q    <= border_d;
            data_q      <= data_d;
            sof_q       <= sof_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef VIDEO_TPG_EN
    // Upstream stream is ignored when the pattern generator owns the pixels.
    logic tpg_inputs_unused;
    assign tpg_inputs_unused = ^{pix_data_i, pix_valid_i, underflow_color_i};
`endif

    // Video outputs go out through the source side of the bus.
    video_bus vbus (.clk(clk_i));

    assign vbus.hsync  = hsync_q;
    assign vbus.vsync  = vsync_q;
    assign vbus.blank  = blank_q;
    assign vbus.border = border_q;
    assign vbus.data   = data_q;

    assign hsync_o     = vbus.hsync;
    assign vsync_o     = vbus.vsync;
    assign blank_o     = vbus.blank;
    assign border_o    = vbus.border;
    assign data_o      = vbus.data;
    assign sof_o       = sof_q;
    assign underflow_o = underflow_q;

endmodule
